iso7816_brg: RTL and testbench

Baud rate generator for the ISO7816 UART path. Divides the system clock into Elementary Time Units (ETU) and drives two single-cycle strobes into the character core. `brg_stb_tx` marks ETU boundaries, where the core launches bits. `brg_stb_rx` marks mid-ETU, where the core samples bits. The core re-phases the generator on each detected start edge through `brg_sync`.

---
 rtl/iso7816_pkg.sv | 17 +
 rtl/iso7816_brg_frac.sv | 33 +++
 rtl/iso7816_brg.sv | 102 ++++++++++
 tb/tb_iso7816_brg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/iso7816_pkg.sv
// Shared constants and types for the ISO7816 UART path.
// Default F/D ETU, minimum ETU, counter width and sync compensation live here.
package iso7816_pkg;

    localparam int ETU_W_DEF     = 16;
    localparam int ETU_MIN       = 4;
    localparam int ETU_FD_DEF    = 372;
    localparam int SYNC_COMP_DEF = 2;
    localparam int FRAC_W        = 8;

    // Direction of the character core; only RX re-phases on a start edge.
    typedef enum logic {
        BRG_MODE_RX = 1'b0,
        BRG_MODE_TX = 1'b1
    } brg_mode_e;

endpackage

// File: rtl/iso7816_brg_frac.sv
// Fractional ETU accumulator: adds cfg_etu_frac at each wrap and flags the
// following ETU as one cycle longer on carry. Used only with ISO7816_BRG_FRAC_EN.
module iso7816_brg_frac
    import iso7816_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac,
    output logic              long_etu
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, frac};

    // long_etu is registered at the wrap, so it shapes the ETU that starts there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            long_etu <= 1'b0;
        end else if (clr) begin
            acc      <= '0;
            long_etu <= 1'b0;
        end else if (step) begin
            acc      <= sum[FRAC_W-1:0];
            long_etu <= sum[FRAC_W];
        end
    end

endmodule

// File: rtl/iso7816_brg.sv
// ETU baud rate generator: boundary (tx) and mid-ETU (rx) strobes, start-edge
// re-phasing, run gating. Fractional ETU support under ISO7816_BRG_FRAC_EN.
module iso7816_brg
    import iso7816_pkg::*;
#(
    parameter int ETU_W     = ETU_W_DEF,
    parameter int SYNC_COMP = SYNC_COMP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ETU_W-1:0] cfg_etu_int,
    input  logic [7:0]       cfg_etu_frac,
    input  logic             brg_run,
    input  logic             brg_sync,
    input  logic             brg_txrx,
    output logic             brg_stb_tx,
    output logic             brg_stb_rx
);

    logic [ETU_W-1:0] cnt;
    logic [ETU_W-1:0] etu_len;
    logic [ETU_W-1:0] etu_half;
    logic [ETU_W-1:0] cfg_len;
    logic [ETU_W:0]   wrap_at;
    logic             run_q;
    logic             run_rise;
    logic             sync_ok;
    logic             wrap_hit;
    logic             half_hit;
    logic             wrap_step;
    logic             long_etu;

    assign cfg_len  = (cfg_etu_int < ETU_W'(ETU_MIN)) ? ETU_W'(ETU_MIN) : cfg_etu_int;
    assign run_rise = brg_run & ~run_q;
    assign sync_ok  = brg_sync & (brg_mode_e'(brg_txrx) == BRG_MODE_RX) & brg_run;

    // One extra bit so a long ETU at the maximum length cannot overflow the compare.
    assign wrap_at  = {1'b0, etu_len} + {{ETU_W{1'b0}}, long_etu} - {{ETU_W{1'b0}}, 1'b1};
    assign wrap_hit = ({1'b0, cnt} == wrap_at);
    assign half_hit = (cnt == (etu_half - ETU_W'(1)));

    assign wrap_step = brg_run & ~sync_ok & ~run_rise & wrap_hit;

`ifdef ISO7816_BRG_FRAC_EN
    iso7816_brg_frac u_frac (
        .clk      (clk),
        .rst      (rst),
        .clr      (~brg_run),
        .step     (wrap_step),
        .frac     (cfg_etu_frac),
        .long_etu (long_etu)
    );
`else
    logic unused_frac;

    assign long_etu    = 1'b0;
    assign unused_frac = ^cfg_etu_frac;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            etu_len    <= ETU_W'(ETU_MIN);
            etu_half   <= ETU_W'(ETU_MIN / 2);
            run_q      <= 1'b0;
            brg_stb_tx <= 1'b0;
            brg_stb_rx <= 1'b0;
        end else begin
            run_q      <= brg_run;
            brg_stb_tx <= 1'b0;
            brg_stb_rx <= 1'b0;
            if (!brg_run) begin
                cnt <= '0;
            end else if (sync_ok) begin
                // Matches from the pre-sync phase are dropped on purpose.
                cnt      <= ETU_W'(SYNC_COMP);
                etu_len  <= cfg_len;
                etu_half <= cfg_len >> 1;
            end else if (run_rise) begin
                // cnt is 0 here, so neither match can fire on the stale length.
                cnt      <= ETU_W'(1);
                etu_len  <= cfg_len;
                etu_half <= cfg_len >> 1;
            end else begin
                if (wrap_hit) begin
                    cnt        <= '0;
                    etu_len    <= cfg_len;
                    etu_half   <= cfg_len >> 1;
                    brg_stb_tx <= 1'b1;
                end else begin
                    cnt <= cnt + ETU_W'(1);
                end
                if (half_hit) begin
                    brg_stb_rx <= 1'b1;
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(brg_stb_tx && brg_stb_rx));

endmodule

// File: tb/tb_iso7816_brg.sv
// Directed bench for iso7816_brg: strobe timestamps against hand-computed
// schedules for free-run, sync, clamp, config change, run gating and reset.
module tb_iso7816_brg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_etu_int;
    logic [7:0]  cfg_etu_frac;
    logic        brg_run;
    logic        brg_sync;
    logic        brg_txrx;
    logic        brg_stb_tx;
    logic        brg_stb_rx;

    logic [31:0] cyc = '0;
    logic [31:0] tx_seen[$];
    logic [31:0] rx_seen[$];
    logic [31:0] exp_tx_q[$];
    logic [31:0] exp_rx_q[$];
    int          checks = 0;
    int          errors = 0;
    int          overlaps = 0;

    typedef struct {
        int cfg_int;
        int sync_off;
        int exp_len;
        int exp_half;
    } vec_t;

    vec_t vecs[7];

    iso7816_brg #(.ETU_W(16), .SYNC_COMP(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_etu_int  (cfg_etu_int),
        .cfg_etu_frac (cfg_etu_frac),
        .brg_run      (brg_run),
        .brg_sync     (brg_sync),
        .brg_txrx     (brg_txrx),
        .brg_stb_tx   (brg_stb_tx),
        .brg_stb_rx   (brg_stb_rx)
    );

    // Clock and cycle stamp
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (brg_stb_tx) tx_seen.push_back(cyc);
        if (brg_stb_rx) rx_seen.push_back(cyc);
        if (brg_stb_tx && brg_stb_rx) overlaps++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push_etus(input logic [31:0] t0, input int len, input int half, input int n);
        for (int k = 0; k < n; k++) begin
            exp_rx_q.push_back(t0 + k * len + half);
            exp_tx_q.push_back(t0 + (k + 1) * len);
        end
    endtask

    // Scoreboard: drain expected queues against observed strobe times
    task automatic expect_strobes(input string tag);
        logic [31:0] e;
        logic [31:0] got;
        while (exp_tx_q.size() > 0) begin
            e   = exp_tx_q.pop_front();
            got = (tx_seen.size() > 0) ? tx_seen.pop_front() : 32'hFFFF_FFFF;
            check({tag, " tx time"}, got, e);
        end
        check({tag, " extra tx"}, tx_seen.size(), 0);
        while (exp_rx_q.size() > 0) begin
            e   = exp_rx_q.pop_front();
            got = (rx_seen.size() > 0) ? rx_seen.pop_front() : 32'hFFFF_FFFF;
            check({tag, " rx time"}, got, e);
        end
        check({tag, " extra rx"}, rx_seen.size(), 0);
        tx_seen.delete();
        rx_seen.delete();
    endtask

    task automatic idle_run();
        brg_run = 1'b0;
        tick(3);
        tx_seen.delete();
        rx_seen.delete();
    endtask

    task automatic raise_run(output logic [31:0] t0);
        brg_run = 1'b1;
        t0      = cyc;
    endtask

    initial begin
        logic [31:0] t0;
        logic [31:0] s;

        vecs[0] = '{1,   1,   4,   2};
        vecs[1] = '{0,   2,   4,   2};
        vecs[2] = '{4,   3,   4,   2};
        vecs[3] = '{5,   4,   5,   2};
        vecs[4] = '{7,   9,   7,   3};
        vecs[5] = '{16,  11,  16,  8};
        vecs[6] = '{372, 200, 372, 186};

        rst          = 1'b1;
        cfg_etu_int  = 16'd372;
        cfg_etu_frac = 8'd0;
        brg_run      = 1'b0;
        brg_sync     = 1'b0;
        brg_txrx     = 1'b1;

        tick(3);
        check("reset tx", brg_stb_tx, 1'b0);
        check("reset rx", brg_stb_rx, 1'b0);
        rst = 1'b0;
        tick(10);
        expect_strobes("idle after reset");

        // Free-run table, sync pulsed but ignored in TX mode
        brg_txrx = 1'b1;
        foreach (vecs[i]) begin
            idle_run();
            cfg_etu_int = 16'(vecs[i].cfg_int);
            raise_run(t0);
            tick(vecs[i].sync_off);
            brg_sync = 1'b1;
            tick(1);
            brg_sync = 1'b0;
            tick(3 * vecs[i].exp_len - vecs[i].sync_off);
            push_etus(t0, vecs[i].exp_len, vecs[i].exp_half, 3);
            expect_strobes($sformatf("freerun cfg=%0d", vecs[i].cfg_int));
        end

        // Sync re-phase in RX mode, second sync lands on the wrap cycle
        idle_run();
        brg_txrx    = 1'b0;
        cfg_etu_int = 16'd16;
        raise_run(t0);
        tick(5);
        s        = cyc;
        brg_sync = 1'b1;
        tick(1);
        brg_sync = 1'b0;
        tick(29);
        brg_sync = 1'b1;
        tick(1);
        brg_sync = 1'b0;
        tick(15);
        exp_rx_q.push_back(s + 7);
        exp_rx_q.push_back(s + 23);
        exp_tx_q.push_back(s + 15);
        exp_rx_q.push_back(s + 37);
        exp_tx_q.push_back(s + 45);
        expect_strobes("sync rephase");

        // Clamp to 4, then a mid-ETU change to 10 applies at the next wrap
        idle_run();
        brg_txrx    = 1'b1;
        cfg_etu_int = 16'd1;
        raise_run(t0);
        tick(5);
        cfg_etu_int = 16'd10;
        tick(24);
        push_etus(t0, 4, 2, 2);
        push_etus(t0 + 8, 10, 5, 2);
        expect_strobes("clamp and change");

        // Run gating mid-ETU
        idle_run();
        cfg_etu_int = 16'd16;
        raise_run(t0);
        tick(5);
        brg_run = 1'b0;
        tick(50);
        expect_strobes("run low");
        raise_run(t0);
        tick(17);
        push_etus(t0, 16, 8, 1);
        expect_strobes("run regained");

        // Asynchronous reset while the rx strobe is high
        idle_run();
        raise_run(t0);
        tick(8);
        check("rx before reset", brg_stb_rx, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset tx", brg_stb_tx, 1'b0);
        check("async reset rx", brg_stb_rx, 1'b0);
        brg_run = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(10);
        expect_strobes("after reset");
        raise_run(t0);
        tick(17);
        push_etus(t0, 16, 8, 1);
        expect_strobes("restart after reset");

        // Fractional ETU: 31 + 64/256
        idle_run();
        cfg_etu_int  = 16'd31;
        cfg_etu_frac = 8'd64;
        raise_run(t0);
        tick(188);
`ifdef ISO7816_BRG_FRAC_EN
        push_etus(t0, 31, 15, 4);
        push_etus(t0 + 124, 32, 15, 1);
        push_etus(t0 + 156, 31, 15, 1);
`else
        push_etus(t0, 31, 15, 6);
`endif
        expect_strobes("fractional");

        check("tx/rx overlap", overlaps, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
